// File: rtl/ibex_fetch_align_fifo_if.sv
// Purpose : handshake/data bundle between the fetch port, the align FIFO and its consumer.
// Latency : none, plain wires.
// Backpress: out_ready_i stalls the consumer side; busy_o throttles new fetch requests.
// Ports   : clear_i/clear_addr_i flush and redirect; in_valid_i/in_rdata_i push a
//           memory word; out_valid_o/out_ready_i/out_rdata_o/out_addr_o present one
//           instruction; busy_o reports near-full occupancy.
interface ibex_fetch_align_fifo_if;
    logic        clear_i;
    logic [31:0] clear_addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        busy_o;

    modport master (
        output clear_i, clear_addr_i, in_valid_i, in_rdata_i, out_ready_i,
        input  out_valid_o, out_rdata_o, out_addr_o, busy_o
    );

    modport slave (
        input  clear_i, clear_addr_i, in_valid_i, in_rdata_i, out_ready_i,
        output out_valid_o, out_rdata_o, out_addr_o, busy_o
    );
endinterface

// File: rtl/ibex_fetch_align_fifo.sv
// Purpose : word FIFO that realigns fetched 32-bit words into 16/32-bit instructions at PC.
// Latency : zero cycles from stored word to out_valid_o; a pushed word is visible the next cycle.
// Backpress: output holds while out_ready_i is low; pushes into a full FIFO are dropped, busy_o warns one entry early.
// Ports   : clk_i, rst_i (async, active-high); bus (slave modport): clear/redirect,
//           word push, instruction output handshake, busy.
module ibex_fetch_align_fifo #(
    parameter int          DEPTH     = 3,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ibex_fetch_align_fifo_if.slave  bus
);

    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;           // thermometer: entry 0 is the oldest
    logic [31:0]      r_pc;

    logic             w_compr;
    logic [31:0]      w_unal_rdata;
    logic             w_out_valid;
    logic [31:0]      w_out_rdata;
    logic             w_consume;
    logic             w_pop;
    logic [31:0]      w_pc_nxt;

    logic [31:0]      w_data_sh  [DEPTH];
    logic [DEPTH-1:0] w_vld_sh;
    logic [31:0]      w_data_nxt [DEPTH];
    logic [DEPTH-1:0] w_vld_nxt;
    logic             w_push_done;

    // The halfword at PC decides the instruction size.
    assign w_compr      = r_pc[1] ? (r_data[0][17:16] != 2'b11)
                                  : (r_data[0][1:0]   != 2'b11);
    assign w_unal_rdata = {r_data[1][15:0], r_data[0][31:16]};

    always_comb begin
        w_out_valid = r_vld[0];
        w_out_rdata = r_data[0];
        if (r_pc[1]) begin
            if (w_compr) begin
                // A compressed instruction is complete in the upper half of entry 0.
                w_out_rdata = r_vld[1] ? w_unal_rdata : {16'h0000, r_data[0][31:16]};
            end else begin
                w_out_rdata = w_unal_rdata;
                w_out_valid = r_vld[0] & r_vld[1];
            end
        end
    end

    assign w_consume = w_out_valid & bus.out_ready_i;
    // Entry 0 is retired unless an aligned compressed instruction leaves its upper half.
    assign w_pop     = w_consume & (r_pc[1] | ~w_compr);
    assign w_pc_nxt  = r_pc + (w_compr ? 32'd2 : 32'd4);

    // Apply this cycle's pop first.
    always_comb begin
        w_data_sh = r_data;
        w_vld_sh  = r_vld;
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_data_sh[i] = r_data[i+1];
                w_vld_sh[i]  = r_vld[i+1];
            end
            w_vld_sh[DEPTH-1] = 1'b0;
        end
    end

    // Then the push lands in the first free slot; with no free slot it is dropped.
    always_comb begin
        w_data_nxt  = w_data_sh;
        w_vld_nxt   = w_vld_sh;
        w_push_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.in_valid_i && !w_push_done && !w_vld_sh[i]) begin
                w_data_nxt[i] = bus.in_rdata_i;
                w_vld_nxt[i]  = 1'b1;
                w_push_done   = 1'b1;
            end
        end
    end

    // Clear wins over consume and push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_pc  <= BOOT_ADDR & 32'hFFFF_FFFE;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (bus.clear_i) begin
            r_vld <= '0;
            r_pc  <= bus.clear_addr_i & 32'hFFFF_FFFE;
        end else begin
            r_data <= w_data_nxt;
            r_vld  <= w_vld_nxt;
            if (w_consume) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    assign bus.out_valid_o = w_out_valid;
    assign bus.out_rdata_o = w_out_rdata;
    assign bus.out_addr_o  = r_pc;
    // Occupancy >= DEPTH-1 is exactly "entry DEPTH-2 is valid" for a thermometer.
    assign bus.busy_o      = r_vld[DEPTH-2];

endmodule
